// File: rtl/uart_regs_if.sv
// APB-side register access bundle: one-cycle write/read strobes, address, write data and read data.
interface uart_regs_if #(
  parameter int ADDR_W = 5
);
  logic              we_i;
  logic              re_i;
  logic [ADDR_W-1:0] PADDR;
  logic [7:0]        PWDATA;
  logic [7:0]        PRDATA;

  modport master (output we_i, re_i, PADDR, PWDATA, input PRDATA);
  modport slave  (input we_i, re_i, PADDR, PWDATA, output PRDATA);
endinterface

// File: rtl/uart_regs.sv
// 16550-style UART register file; acts on front-end strobes, registered PRDATA/pulses/int_o.
// Optional SCR storage at index 7 is built only when UART_REGS_SCRATCH_EN is defined.
module uart_regs #(
  parameter int          ADDR_W  = 5,
  parameter logic [7:0]  RST_LCR = 8'h03,
  parameter logic [15:0] RST_DIV = 16'h0001
) (
  input  logic        PCLK,
  input  logic        PRESET,
  uart_regs_if.slave  bus,
  output logic        tx_push,
  output logic [7:0]  tx_data,
  input  logic        tx_full,
  input  logic        tx_empty,
  input  logic        tx_idle,
  output logic        rx_pop,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  input  logic        rx_overrun,
  output logic [1:0]  fifo_clr,
  output logic [7:0]  lcr_o,
  output logic [4:0]  mcr_o,
  output logic [15:0] divisor_o,
  output logic        int_o
);

  logic [7:0] prdata_q, prdata_d;
  logic       tx_push_q, tx_push_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       rx_pop_q, rx_pop_d;
  logic [1:0] fifo_clr_q, fifo_clr_d;
  logic [7:0] lcr_q, lcr_d;
  logic [4:0] mcr_q, mcr_d;
  logic [7:0] dll_q, dll_d;
  logic [7:0] dlm_q, dlm_d;
  logic [3:0] ier_q, ier_d;
  logic       oe_q, oe_d;
  logic       thre_q, thre_d;
  logic       tx_empty_q, tx_empty_d;
  logic       int_q, int_d;
`ifdef UART_REGS_SCRATCH_EN
  logic [7:0] scr_q, scr_d;
`endif

  logic       dlab, wr, rd, pending, oe_clr, thre_clr, thre_set;
  logic [2:0] idx, id;
  logic [7:0] iir, lsr;
  logic       unused_ok;

  assign dlab      = lcr_q[7];
  assign idx       = bus.PADDR[4:2];
  assign wr        = bus.we_i;
  assign rd        = bus.re_i & ~bus.we_i;
  assign unused_ok = ^bus.PADDR;

  always_comb begin
    id      = 3'b000;
    pending = 1'b0;
    if (oe_q && ier_q[2]) begin
      id = 3'b011; pending = 1'b1;
    end else if (!rx_empty && ier_q[0]) begin
      id = 3'b010; pending = 1'b1;
    end else if (thre_q && ier_q[1]) begin
      id = 3'b001; pending = 1'b1;
    end
  end

  assign iir = {4'hC, id, ~pending};
  assign lsr = {1'b0, tx_empty & tx_idle, tx_empty, 3'b000, oe_q, ~rx_empty};

  always_comb begin
    prdata_d   = prdata_q;
    tx_push_d  = 1'b0;
    tx_data_d  = tx_data_q;
    rx_pop_d   = 1'b0;
    fifo_clr_d = 2'b00;
    lcr_d      = lcr_q;
    mcr_d      = mcr_q;
    dll_d      = dll_q;
    dlm_d      = dlm_q;
    ier_d      = ier_q;
    tx_empty_d = tx_empty;
    int_d      = pending;
    oe_clr     = 1'b0;
    thre_clr   = 1'b0;
    thre_set   = tx_empty & ~tx_empty_q;
`ifdef UART_REGS_SCRATCH_EN
    scr_d      = scr_q;
`endif
    if (wr) begin
      case (idx)
        3'd0: if (dlab) dll_d = bus.PWDATA;
              else begin
                thre_clr = 1'b1;
                if (!tx_full) begin
                  tx_push_d = 1'b1;
                  tx_data_d = bus.PWDATA;
                end
              end
        3'd1: if (dlab) dlm_d = bus.PWDATA;
              else begin
                ier_d = bus.PWDATA[3:0];
                if (bus.PWDATA[1] && tx_empty) thre_set = 1'b1;
              end
        3'd2: fifo_clr_d = {bus.PWDATA[2], bus.PWDATA[1]};
        3'd3: lcr_d = bus.PWDATA;
        3'd4: mcr_d = bus.PWDATA[4:0];
`ifdef UART_REGS_SCRATCH_EN
        3'd7: scr_d = bus.PWDATA;
`endif
        default: ;
      endcase
    end
    if (rd) begin
      case (idx)
        3'd0: if (dlab) prdata_d = dll_q;
              else if (!rx_empty) begin
                prdata_d = rx_data;
                rx_pop_d = 1'b1;
              end else prdata_d = 8'h00;
        3'd1: prdata_d = dlab ? dlm_q : {4'h0, ier_q};
        3'd2: begin
          prdata_d = iir;
          // Only a THRE-sourced IIR read acknowledges the THRE interrupt.
          if (pending && id == 3'b001) thre_clr = 1'b1;
        end
        3'd3: prdata_d = lcr_q;
        3'd4: prdata_d = {3'b000, mcr_q};
        3'd5: begin
          prdata_d = lsr;
          oe_clr   = 1'b1;
        end
`ifdef UART_REGS_SCRATCH_EN
        3'd7: prdata_d = scr_q;
`endif
        default: prdata_d = 8'h00;
      endcase
    end
    oe_d   = rx_overrun ? 1'b1 : (oe_clr ? 1'b0 : oe_q);
    thre_d = thre_clr ? 1'b0 : (thre_set ? 1'b1 : thre_q);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      prdata_q   <= 8'h00;
      tx_push_q  <= 1'b0;
      tx_data_q  <= 8'h00;
      rx_pop_q   <= 1'b0;
      fifo_clr_q <= 2'b00;
      lcr_q      <= RST_LCR;
      mcr_q      <= 5'h00;
      dll_q      <= RST_DIV[7:0];
      dlm_q      <= RST_DIV[15:8];
      ier_q      <= 4'h0;
      oe_q       <= 1'b0;
      thre_q     <= 1'b0;
      tx_empty_q <= 1'b1;  // no spurious THRE edge straight out of reset
      int_q      <= 1'b0;
`ifdef UART_REGS_SCRATCH_EN
      scr_q      <= 8'h00;
`endif
    end else begin
      prdata_q   <= prdata_d;
      tx_push_q  <= tx_push_d;
      tx_data_q  <= tx_data_d;
      rx_pop_q   <= rx_pop_d;
      fifo_clr_q <= fifo_clr_d;
      lcr_q      <= lcr_d;
      mcr_q      <= mcr_d;
      dll_q      <= dll_d;
      dlm_q      <= dlm_d;
      ier_q      <= ier_d;
      oe_q       <= oe_d;
      thre_q     <= thre_d;
      tx_empty_q <= tx_empty_d;
      int_q      <= int_d;
`ifdef UART_REGS_SCRATCH_EN
      scr_q      <= scr_d;
`endif
    end
  end

  assign bus.PRDATA = prdata_q;
  assign tx_push    = tx_push_q;
  assign tx_data    = tx_data_q;
  assign rx_pop     = rx_pop_q;
  assign fifo_clr   = fifo_clr_q;
  assign lcr_o      = lcr_q;
  assign mcr_o      = mcr_q;
  assign divisor_o  = {dlm_q, dll_q};
  assign int_o      = int_q;

endmodule

// File: tb/tb_uart_regs.sv
// Directed checks of the uart_regs register map, strobes, interrupt priority and reset behaviour.
module tb_uart_regs;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_push, tx_full, tx_empty, tx_idle;
  logic [7:0]  tx_data, rx_data, lcr_o;
  logic        rx_pop, rx_empty, rx_overrun, int_o;
  logic [1:0]  fifo_clr;
  logic [4:0]  mcr_o;
  logic [15:0] divisor_o;
  int          vectors = 0;
  int          miscompares = 0;

  uart_regs_if #(.ADDR_W(5)) bus ();

  uart_regs #(.ADDR_W(5), .RST_LCR(8'h03), .RST_DIV(16'h0001)) dut (
    .PCLK(clk), .PRESET(rst), .bus(bus),
    .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full), .tx_empty(tx_empty),
    .tx_idle(tx_idle), .rx_pop(rx_pop), .rx_data(rx_data), .rx_empty(rx_empty),
    .rx_overrun(rx_overrun), .fifo_clr(fifo_clr), .lcr_o(lcr_o), .mcr_o(mcr_o),
    .divisor_o(divisor_o), .int_o(int_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] idx, input logic [7:0] d);
    bus.we_i = 1'b1; bus.PADDR = {idx, 2'b00}; bus.PWDATA = d;
    @(negedge clk);
    bus.we_i = 1'b0;
  endtask

  task automatic rd(input logic [2:0] idx);
    bus.re_i = 1'b1; bus.PADDR = {idx, 2'b11};
    @(negedge clk);
    bus.re_i = 1'b0;
  endtask

  initial begin
    bus.we_i = 1'b0; bus.re_i = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
    tx_full = 1'b0; tx_empty = 1'b1; tx_idle = 1'b1;
    rx_data = 8'h00; rx_empty = 1'b1; rx_overrun = 1'b0;
    #12;
    chk("rst_prdata", {8'h0, bus.PRDATA}, 16'h0000);
    chk("rst_lcr", {8'h0, lcr_o}, 16'h0003);
    chk("rst_div", divisor_o, 16'h0001);
    chk("rst_strobes", {11'h0, tx_push, rx_pop, fifo_clr, int_o}, 16'h0000);
    chk("rst_mcr_txd", {3'h0, mcr_o, tx_data}, 16'h0000);
    @(negedge clk); rst = 1'b0; tick();

    rd(3'd3); chk("rd_lcr", {8'h0, bus.PRDATA}, 16'h0003);
    rd(3'd5); chk("rd_lsr_idle", {8'h0, bus.PRDATA}, 16'h0060);
    chk("int_idle", {15'h0, int_o}, 16'h0000);

    wr(3'd3, 8'h83); wr(3'd0, 8'h1A);
    chk("no_push_dll", {15'h0, tx_push}, 16'h0000);
    wr(3'd1, 8'h00); wr(3'd3, 8'h03);
    chk("divisor", divisor_o, 16'h001A);
    chk("lcr_back", {8'h0, lcr_o}, 16'h0003);

    wr(3'd0, 8'h55);
    chk("thr_push", {7'h0, tx_push, tx_data}, 16'h0155);
    tick(); chk("thr_push_end", {15'h0, tx_push}, 16'h0000);
    tx_full = 1'b1; wr(3'd0, 8'h66);
    chk("thr_full_drop", {7'h0, tx_push, tx_data}, 16'h0055);
    tx_full = 1'b0;

    wr(3'd2, 8'h06); chk("fcr_pulse", {14'h0, fifo_clr}, 16'h0003);
    tick(); chk("fcr_end", {14'h0, fifo_clr}, 16'h0000);
    wr(3'd2, 8'h04); chk("fcr_tx_only", {14'h0, fifo_clr}, 16'h0002);
    wr(3'd4, 8'hFF); chk("mcr", {11'h0, mcr_o}, 16'h001F);
    rd(3'd4); chk("rd_mcr", {8'h0, bus.PRDATA}, 16'h001F);

    rx_empty = 1'b0; rx_data = 8'hA5;
    wr(3'd1, 8'h01); tick();
    chk("int_rx", {15'h0, int_o}, 16'h0001);
    rd(3'd2); chk("iir_rx", {8'h0, bus.PRDATA}, 16'h00C4);
    rd(3'd0); chk("rbr", {7'h0, rx_pop, bus.PRDATA}, 16'h01A5);
    rx_empty = 1'b1;
    tick(); chk("pop_end", {15'h0, rx_pop}, 16'h0000);
    chk("int_rx_drop", {15'h0, int_o}, 16'h0000);
    rd(3'd0); chk("rbr_empty", {7'h0, rx_pop, bus.PRDATA}, 16'h0000);

    wr(3'd1, 8'h04);
    rx_overrun = 1'b1; tick(); rx_overrun = 1'b0; tick();
    chk("int_oe", {15'h0, int_o}, 16'h0001);
    rd(3'd2); chk("iir_oe", {8'h0, bus.PRDATA}, 16'h00C6);
    rd(3'd5); chk("lsr_oe", {8'h0, bus.PRDATA}, 16'h0062);
    rd(3'd5); chk("lsr_oe_clr", {8'h0, bus.PRDATA}, 16'h0060);
    chk("int_oe_drop", {15'h0, int_o}, 16'h0000);
    rx_overrun = 1'b1; rd(3'd5); rx_overrun = 1'b0;
    chk("lsr_race_rd", {8'h0, bus.PRDATA}, 16'h0060);
    rd(3'd5); chk("lsr_set_wins", {8'h0, bus.PRDATA}, 16'h0062);

    wr(3'd1, 8'h00);
    tx_empty = 1'b0; wr(3'd1, 8'h02); tick();
    chk("int_thre_none", {15'h0, int_o}, 16'h0000);
    tx_empty = 1'b1; tick(); tick();
    chk("int_thre", {15'h0, int_o}, 16'h0001);
    rd(3'd2); chk("iir_thre", {8'h0, bus.PRDATA}, 16'h00C2);
    rd(3'd2); chk("iir_thre_clr", {8'h0, bus.PRDATA}, 16'h00C1);
    chk("int_thre_drop", {15'h0, int_o}, 16'h0000);
    wr(3'd1, 8'h00); wr(3'd1, 8'h02);
    rd(3'd2); chk("iir_ier_set", {8'h0, bus.PRDATA}, 16'h00C2);
    rd(3'd2); chk("iir_ier_clr", {8'h0, bus.PRDATA}, 16'h00C1);
    tx_empty = 1'b0; tick();
    tx_empty = 1'b1; wr(3'd0, 8'h11);
    rd(3'd2); chk("thre_clr_prio", {8'h0, bus.PRDATA}, 16'h00C1);

    wr(3'd7, 8'h3C); rd(3'd7);
`ifdef UART_REGS_SCRATCH_EN
    chk("scr", {8'h0, bus.PRDATA}, 16'h003C);
`else
    chk("scr_absent", {8'h0, bus.PRDATA}, 16'h0000);
`endif

    rd(3'd3);
    bus.we_i = 1'b1; bus.re_i = 1'b1; bus.PADDR = {3'd4, 2'b00}; bus.PWDATA = 8'h0A;
    tick(); bus.we_i = 1'b0; bus.re_i = 1'b0;
    chk("we_re_prdata", {8'h0, bus.PRDATA}, 16'h0003);
    chk("we_re_mcr", {11'h0, mcr_o}, 16'h000A);

    bus.we_i = 1'b1; bus.PADDR = 5'd0; bus.PWDATA = 8'h77;
    @(posedge clk); #1;
    chk("pre_rst_push", {7'h0, tx_push, tx_data}, 16'h0177);
    rst = 1'b1; #1;
    chk("mid_rst_out", {7'h0, tx_push, bus.PRDATA}, 16'h0000);
    chk("mid_rst_regs", {3'h0, mcr_o, lcr_o}, 16'h0003);
    bus.we_i = 1'b0;
    @(negedge clk); rst = 1'b0; tick();
    chk("post_rst", {11'h0, tx_push, rx_pop, fifo_clr, int_o}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_regs.md
Name: uart_regs

Overview:
- Register-file stage directly downstream of the UART APB front end.
- Consumes its one-cycle we/re strobes together with PADDR/PWDATA.
- Decodes a 16550-style register map; produces PRDATA, TX FIFO push, RX FIFO pop, line/divisor configuration and the UART interrupt.
- Sits between the APB front end and the TX/RX FIFOs and baud generator.

Parameters:
- ADDR_W, 5, APB byte-address width; register index = PADDR[4:2]
- RST_LCR, 8'h03, LCR reset value (8N1)
- RST_DIV, 16'h0001, divisor latch reset value

Ports:
- PCLK  in  1  clock
- PRESET  in  1  asynchronous active-high reset
- we_i  in  1  single-cycle write strobe from APB front end
- re_i  in  1  single-cycle read strobe from APB front end
- PADDR  in  ADDR_W  register byte address
- PWDATA  in  8  write data
- PRDATA  out  8  registered read data
- tx_push  out  1  one-cycle TX FIFO push
- tx_data  out  8  TX FIFO write data
- tx_full  in  1  TX FIFO full
- tx_empty  in  1  TX FIFO empty
- tx_idle  in  1  transmitter shift register idle
- rx_pop  out  1  one-cycle RX FIFO pop
- rx_data  in  8  RX FIFO head data
- rx_empty  in  1  RX FIFO empty
- rx_overrun  in  1  one-cycle overrun pulse from receiver
- fifo_clr  out  2  one-cycle FCR clear pulses: [0] RX, [1] TX
- lcr_o  out  8  line control register
- mcr_o  out  5  modem control register
- divisor_o  out  16  {DLM,DLL}
- int_o  out  1  registered interrupt request

Behaviour:
- Reset (async, PRESET=1) values:
  - PRDATA=0, tx_push=0, tx_data=0, rx_pop=0, fifo_clr=0, int_o=0
  - lcr_o=RST_LCR, mcr_o=0, divisor_o=RST_DIV, IER=0, SCR=0, OE=0, thre_pend=0
- DLAB = lcr_o[7].
- Register index i = PADDR[4:2]; PADDR[1:0] ignored.
- Write map, acted on in the we_i cycle; registers update at the next edge:
  - i=0, DLAB=0: THR. tx_push=1 and tx_data=PWDATA next cycle if tx_full=0; if tx_full=1 the data is dropped with no push. Clears thre_pend.
  - i=0, DLAB=1: DLL.
  - i=1, DLAB=0: IER[3:0]. i=1, DLAB=1: DLM.
  - i=2: FCR. fifo_clr={PWDATA[2],PWDATA[1]} pulsed one cycle.
  - i=3: LCR. i=4: MCR[4:0]. i=5, i=6: ignored. i=7: SCR.
- Read map: PRDATA is loaded at the edge ending the re_i cycle and held until the next re_i. This gives 1-cycle latency, aligned with the front end's PREADY.
  - i=0, DLAB=0: RBR. PRDATA=rx_data and rx_pop=1 for one cycle if rx_empty=0; otherwise PRDATA=8'h00 and no pop.
  - i=0, DLAB=1: DLL. i=1: IER (DLAB=0) / DLM (DLAB=1).
  - i=2: IIR = {4'hC, id[2:0], ~pending}. Reading it clears thre_pend when THRE is the reported source.
  - i=3: LCR. i=4: {3'b0, MCR}.
  - i=5: LSR = {1'b0, tx_empty&tx_idle, tx_empty, 3'b0, OE, ~rx_empty}. Reading it clears OE.
  - i=6: 8'h00. i=7: SCR.
- OE: set by rx_overrun. If set and cleared in the same cycle, set wins.
- thre_pend:
  - Set on the cycle tx_empty rises.
  - Also set on an IER write that enables bit1 while tx_empty=1.
  - Clear has priority over a same-cycle set from the tx_empty edge.
- Interrupt priority (highest first), giving id:
  - OE & IER[2] -> 3'b011
  - ~rx_empty & IER[0] -> 3'b010
  - thre_pend & IER[1] -> 3'b001
  - none -> id=0, pending=0
- int_o = registered pending; 1 cycle after the source changes.
- we_i and re_i together (illegal upstream): write performed, read ignored, PRDATA unchanged.
- Reset mid-access: all strobes and outputs return to reset values immediately; no push/pop is issued.

Optional Feature:
- Macro: UART_REGS_SCRATCH_EN.
- Defined: SCR register at i=7 is read/write as above.
- Undefined: no SCR storage; writes to i=7 are ignored and reads return 8'h00.

Test Plan:
- Reset, then read i=3 and i=5 with tx_empty=1, tx_idle=1, rx_empty=1 -> PRDATA 8'h03 then 8'h60; int_o=0.
- Write LCR=8'h83, DLL=8'h1A, DLM=8'h00, LCR=8'h03 -> divisor_o=16'h001A, lcr_o=8'h03, no tx_push during the DLL write.
- Write THR 8'h55 with tx_full=0 -> tx_push pulse one cycle later with tx_data=8'h55. Repeat with tx_full=1 -> no push.
- rx_empty=0, rx_data=8'hA5, IER=8'h01 -> int_o=1, IIR read=8'hC4; RBR read -> PRDATA=8'hA5 with a single rx_pop pulse.
- IER=8'h04, pulse rx_overrun -> IIR=8'hC6, LSR bit1=1; LSR read clears OE, next LSR read bit1=0; int_o drops.
- IER=8'h02, tx_empty rising -> IIR=8'hC2; IIR read -> IIR next read=8'hC1, int_o=0. Repeat with UART_REGS_SCRATCH_EN undefined: SCR write 8'h3C, read -> 8'h00.
